// File: rtl/alu_sequencer_if.sv
// Bundle of the requester, ALU and response signals around alu_sequencer.
//
// Handshake rule shared by every channel here: a transfer happens on the
// rising clock edge where valid and ready are both high. A source may drop
// valid before it is accepted; once rsp_valid is raised the response fields
// stay stable until that transfer edge.
interface alu_sequencer_if #(
    parameter int DATA_BUS = 8,
    parameter int OP_BUS   = 6
);
    logic                req0_valid;
    logic                req0_ready;
    logic [DATA_BUS-1:0] req0_a;
    logic [DATA_BUS-1:0] req0_b;
    logic [OP_BUS-1:0]   req0_op;

    logic                req1_valid;
    logic                req1_ready;
    logic [DATA_BUS-1:0] req1_a;
    logic [DATA_BUS-1:0] req1_b;
    logic [OP_BUS-1:0]   req1_op;

    logic [DATA_BUS-1:0] alu_op_a_bus;
    logic [DATA_BUS-1:0] alu_op_b_bus;
    logic [OP_BUS-1:0]   alu_op_code_bus;
    logic [2:0]          alu_enables;
    logic [DATA_BUS:0]   alu_result_bus;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_BUS:0]   rsp_result;
    logic                rsp_id;
    logic                rsp_illegal;

    // Sequencer side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output alu_op_a_bus, alu_op_b_bus, alu_op_code_bus, alu_enables,
        input  alu_result_bus,
        output rsp_valid, rsp_result, rsp_id, rsp_illegal,
        input  rsp_ready
    );

    // Requester / ALU / consumer side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  alu_op_a_bus, alu_op_b_bus, alu_op_code_bus, alu_enables,
        output alu_result_bus,
        input  rsp_valid, rsp_result, rsp_id, rsp_illegal,
        output rsp_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// Round-robin sequencer in front of the 8-bit ALU: accepts one transaction
// from either requester, walks the ALU through load/execute, captures the
// registered result and returns it tagged with the requester ID. Opcodes the
// ALU does not implement are answered immediately with result 0 and the
// illegal flag, without loading the ALU.
module alu_sequencer #(
    parameter int DATA_BUS = 8,
    parameter int OP_BUS   = 6
) (
    input  logic                clock,
    input  logic                reset_n,
    alu_sequencer_if.slave      bus,
    output logic                busy,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        EXEC = 3'd2,
        CAPT = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [OP_BUS-1:0] OP_ADD = OP_BUS'(6'h20);
    localparam logic [OP_BUS-1:0] OP_SUB = OP_BUS'(6'h22);
    localparam logic [OP_BUS-1:0] OP_AND = OP_BUS'(6'h24);
    localparam logic [OP_BUS-1:0] OP_OR  = OP_BUS'(6'h25);
    localparam logic [OP_BUS-1:0] OP_XOR = OP_BUS'(6'h26);
    localparam logic [OP_BUS-1:0] OP_NOR = OP_BUS'(6'h27);
    localparam logic [OP_BUS-1:0] OP_SRA = OP_BUS'(6'h03);
    localparam logic [OP_BUS-1:0] OP_SRL = OP_BUS'(6'h02);

    function automatic logic is_legal(input logic [OP_BUS-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL:
                is_legal = 1'b1;
            default:
                is_legal = 1'b0;
        endcase
    endfunction

    state_t              state_q;
    state_t              state_d;
    logic                last_grant_q;
    logic [DATA_BUS-1:0] a_q;
    logic [DATA_BUS-1:0] b_q;
    logic [OP_BUS-1:0]   op_q;
    logic [DATA_BUS:0]   rsp_result_q;
    logic                rsp_id_q;
    logic                rsp_illegal_q;

    logic                any_valid;
    logic                grant_id;
    logic [DATA_BUS-1:0] sel_a;
    logic [DATA_BUS-1:0] sel_b;
    logic [OP_BUS-1:0]   sel_op;
    logic                sel_legal;
    logic                ready_0;
    logic                ready_1;
    logic                accept;
    logic [2:0]          enables;
    logic                rsp_valid_c;

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
        sel_a     = grant_id ? bus.req1_a  : bus.req0_a;
        sel_b     = grant_id ? bus.req1_b  : bus.req0_b;
        sel_op    = grant_id ? bus.req1_op : bus.req0_op;
        sel_legal = is_legal(sel_op);
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state outputs; readys are held low while in reset.
    always_comb begin
        state_d     = state_q;
        ready_0     = 1'b0;
        ready_1     = 1'b0;
        enables     = 3'b000;
        rsp_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (reset_n && any_valid) begin
                    ready_0 = ~grant_id;
                    ready_1 = grant_id;
                    state_d = sel_legal ? LOAD : RESP;
                end
            end
            LOAD: begin
                enables = 3'b111;
                state_d = EXEC;
            end
            EXEC: state_d = CAPT;
            CAPT: state_d = RESP;
            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        accept = ready_0 | ready_1;
    end

    // Transaction latch, ALU bus hold registers and response capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q  <= 1'b1;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            rsp_result_q  <= '0;
            rsp_id_q      <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                last_grant_q <= grant_id;
                rsp_id_q     <= grant_id;
                if (sel_legal) begin
                    // Buses only move for work the ALU will actually do.
                    a_q  <= sel_a;
                    b_q  <= sel_b;
                    op_q <= sel_op;
                end else begin
                    rsp_result_q  <= '0;
                    rsp_illegal_q <= 1'b1;
                end
            end
            if (state_q == CAPT) begin
                rsp_result_q  <= bus.alu_result_bus;
                rsp_illegal_q <= 1'b0;
            end
        end
    end

    assign bus.req0_ready      = ready_0;
    assign bus.req1_ready      = ready_1;
    assign bus.alu_op_a_bus    = a_q;
    assign bus.alu_op_b_bus    = b_q;
    assign bus.alu_op_code_bus = op_q;
    assign bus.alu_enables     = enables;
    assign bus.rsp_valid       = rsp_valid_c;
    assign bus.rsp_result      = rsp_result_q;
    assign bus.rsp_id          = rsp_id_q;
    assign bus.rsp_illegal     = rsp_illegal_q;
    assign busy                = (state_q != IDLE);
    assign state_dbg           = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus randomized traffic checked
// against a transaction-level model of arbitration, latency and results.
module tb_alu_sequencer;
    localparam int DW = 8;
    localparam int OW = 6;

    logic       clock;
    logic       reset_n;
    logic       busy;
    logic [2:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];
    logic        m_last;

    alu_sequencer_if #(.DATA_BUS(DW), .OP_BUS(OW)) bus_if ();

    alu_sequencer #(.DATA_BUS(DW), .OP_BUS(OW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus_if),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ALU behaviour as seen from the sequencer: 9-bit registered result.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   alu_fn = {1'b0, a} + {1'b0, b};
            6'h22:   alu_fn = {1'b0, a - b};
            6'h24:   alu_fn = {1'b0, a & b};
            6'h25:   alu_fn = {1'b0, a | b};
            6'h26:   alu_fn = {1'b0, a ^ b};
            6'h27:   alu_fn = {1'b0, ~(a | b)};
            6'h03:   alu_fn = {a[0], a[7], a[7:1]};
            6'h02:   alu_fn = {a[0], 1'b0, a[7:1]};
            default: alu_fn = 9'h000;
        endcase
    endfunction

    function automatic logic op_ok(input logic [5:0] op);
        op_ok = (op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02});
    endfunction

    always @(posedge clock) begin
        if (bus_if.alu_enables == 3'b111) begin
            bus_if.alu_result_bus <= alu_fn(bus_if.alu_op_a_bus, bus_if.alu_op_b_bus, bus_if.alu_op_code_bus);
        end
    end

    // Driver tasks.
    task automatic do_reset();
        reset_n = 1'b0;
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        if (id == 0) begin
            bus_if.req0_a = a; bus_if.req0_b = b; bus_if.req0_op = op; bus_if.req0_valid = 1'b1;
        end else begin
            bus_if.req1_a = a; bus_if.req1_b = b; bus_if.req1_op = op; bus_if.req1_valid = 1'b1;
        end
    endtask

    // Called just after the accept edge; counts edges until rsp_valid and
    // the cycles with all ALU enables high. Bounded at 20 edges.
    task automatic wait_rsp(output int lat, output int en_cnt);
        lat    = 0;
        en_cnt = (bus_if.alu_enables == 3'b111) ? 1 : 0;
        while (bus_if.rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
            if (bus_if.alu_enables == 3'b111) en_cnt++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_req(0, 8'h12, 8'h34, 6'h20);
        drive_req(1, 8'h56, 8'h78, 6'h22);
        repeat (3) @(posedge clock);
        #1;
        checks++; if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b00) begin failures++; $display("FAIL reset_readys got=%b exp=00", {bus_if.req1_ready, bus_if.req0_ready}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bus_if.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus_if.rsp_valid); end
        checks++; if (bus_if.alu_enables !== 3'b000) begin failures++; $display("FAIL reset_enables got=%b exp=000", bus_if.alu_enables); end
        checks++; if ({bus_if.alu_op_a_bus, bus_if.alu_op_b_bus, bus_if.alu_op_code_bus} !== 22'h0) begin failures++; $display("FAIL reset_buses got=%h exp=0", {bus_if.alu_op_a_bus, bus_if.alu_op_b_bus, bus_if.alu_op_code_bus}); end
        checks++; if ({bus_if.rsp_result, bus_if.rsp_id, bus_if.rsp_illegal} !== 11'h0) begin failures++; $display("FAIL reset_rsp_fields got=%h exp=0", {bus_if.rsp_result, bus_if.rsp_id, bus_if.rsp_illegal}); end
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_single();
        int lat, en;
        bus_if.rsp_ready = 1'b1;
        drive_req(0, 8'h0F, 8'h01, 6'h20);
        #1;
        checks++; if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", {bus_if.req1_ready, bus_if.req0_ready}); end
        @(posedge clock);
        #1;
        bus_if.req0_valid = 1'b0;
        checks++; if ({bus_if.alu_op_a_bus, bus_if.alu_op_b_bus, bus_if.alu_op_code_bus} !== {8'h0F, 8'h01, 6'h20}) begin failures++; $display("FAIL single_buses got=%h exp=%h", {bus_if.alu_op_a_bus, bus_if.alu_op_b_bus, bus_if.alu_op_code_bus}, {8'h0F, 8'h01, 6'h20}); end
        wait_rsp(lat, en);
        checks++; if (lat != 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", lat); end
        checks++; if (en != 1) begin failures++; $display("FAIL single_enable_cycles got=%0d exp=1", en); end
        checks++; if ({bus_if.rsp_id, bus_if.rsp_illegal, bus_if.rsp_result} !== {1'b0, 1'b0, 9'h010}) begin failures++; $display("FAIL single_rsp got=%h exp=%h", {bus_if.rsp_id, bus_if.rsp_illegal, bus_if.rsp_result}, {1'b0, 1'b0, 9'h010}); end
        @(posedge clock);
        #1;
        checks++; if ({busy, bus_if.rsp_valid} !== 2'b00) begin failures++; $display("FAIL single_idle got=%b exp=00", {busy, bus_if.rsp_valid}); end
        checks++; if (bus_if.alu_op_a_bus !== 8'h0F) begin failures++; $display("FAIL single_bus_hold got=%h exp=0f", bus_if.alu_op_a_bus); end
    endtask

    task automatic test_contention();
        int lat, en;
        do_reset();
        bus_if.rsp_ready = 1'b1;
        drive_req(0, 8'hF0, 8'h0F, 6'h25);
        drive_req(1, 8'h81, 8'h00, 6'h03);
        #1;
        checks++; if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b01) begin failures++; $display("FAIL cont_first_grant got=%b exp=01", {bus_if.req1_ready, bus_if.req0_ready}); end
        @(posedge clock);
        #1;
        drive_req(0, 8'h80, 8'h80, 6'h20);
        wait_rsp(lat, en);
        checks++; if ({bus_if.rsp_id, bus_if.rsp_result} !== {1'b0, 9'h0FF}) begin failures++; $display("FAIL cont_rsp0 got=%h exp=%h", {bus_if.rsp_id, bus_if.rsp_result}, {1'b0, 9'h0FF}); end
        @(posedge clock);
        #1;
        checks++; if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b10) begin failures++; $display("FAIL cont_second_grant got=%b exp=10", {bus_if.req1_ready, bus_if.req0_ready}); end
        @(posedge clock);
        #1;
        bus_if.req1_valid = 1'b0;
        wait_rsp(lat, en);
        checks++; if ({bus_if.rsp_id, bus_if.rsp_result} !== {1'b1, 9'h1C0}) begin failures++; $display("FAIL cont_rsp1 got=%h exp=%h", {bus_if.rsp_id, bus_if.rsp_result}, {1'b1, 9'h1C0}); end
        @(posedge clock);
        #1;
        checks++; if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b01) begin failures++; $display("FAIL cont_third_grant got=%b exp=01", {bus_if.req1_ready, bus_if.req0_ready}); end
        @(posedge clock);
        #1;
        bus_if.req0_valid = 1'b0;
        wait_rsp(lat, en);
        checks++; if ({bus_if.rsp_id, bus_if.rsp_result} !== {1'b0, 9'h100}) begin failures++; $display("FAIL cont_rsp2 got=%h exp=%h", {bus_if.rsp_id, bus_if.rsp_result}, {1'b0, 9'h100}); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_illegal();
        int lat, en;
        bus_if.rsp_ready = 1'b1;
        drive_req(1, 8'h55, 8'h66, 6'h3F);
        #1;
        checks++; if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b10) begin failures++; $display("FAIL illegal_ready got=%b exp=10", {bus_if.req1_ready, bus_if.req0_ready}); end
        @(posedge clock);
        #1;
        bus_if.req1_valid = 1'b0;
        wait_rsp(lat, en);
        checks++; if (lat != 0) begin failures++; $display("FAIL illegal_latency got=%0d exp=0", lat); end
        checks++; if (en != 0) begin failures++; $display("FAIL illegal_enables got=%0d exp=0", en); end
        checks++; if ({bus_if.rsp_id, bus_if.rsp_illegal, bus_if.rsp_result} !== {1'b1, 1'b1, 9'h000}) begin failures++; $display("FAIL illegal_rsp got=%h exp=%h", {bus_if.rsp_id, bus_if.rsp_illegal, bus_if.rsp_result}, {1'b1, 1'b1, 9'h000}); end
        checks++; if ({bus_if.alu_op_a_bus, bus_if.alu_op_code_bus} !== {8'h80, 6'h20}) begin failures++; $display("FAIL illegal_bus_hold got=%h exp=%h", {bus_if.alu_op_a_bus, bus_if.alu_op_code_bus}, {8'h80, 6'h20}); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_backpressure();
        int lat, en;
        bus_if.rsp_ready = 1'b0;
        drive_req(0, 8'h05, 8'h07, 6'h22);
        @(posedge clock);
        #1;
        bus_if.req0_valid = 1'b0;
        drive_req(1, 8'h01, 8'h02, 6'h20);
        wait_rsp(lat, en);
        checks++; if (lat != 3) begin failures++; $display("FAIL bp_latency got=%0d exp=3", lat); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({bus_if.rsp_valid, bus_if.rsp_result} !== {1'b1, 9'h0FE}) begin failures++; $display("FAIL bp_hold%0d got=%h exp=%h", i, {bus_if.rsp_valid, bus_if.rsp_result}, {1'b1, 9'h0FE}); end
            checks++; if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b00) begin failures++; $display("FAIL bp_readys%0d got=%b exp=00", i, {bus_if.req1_ready, bus_if.req0_ready}); end
            @(posedge clock);
            #1;
        end
        bus_if.req1_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        checks++; if ({busy, bus_if.rsp_valid} !== 2'b00) begin failures++; $display("FAIL bp_release got=%b exp=00", {busy, bus_if.rsp_valid}); end
    endtask

    task automatic test_reset_mid();
        int lat, en;
        bit seen;
        bus_if.rsp_ready = 1'b1;
        drive_req(0, 8'h33, 8'h44, 6'h26);
        @(posedge clock);
        #1;
        bus_if.req0_valid = 1'b0;
        @(posedge clock);
        #1;
        checks++; if ({busy, bus_if.alu_enables} !== 4'b1000) begin failures++; $display("FAIL mid_exec got=%b exp=1000", {busy, bus_if.alu_enables}); end
        drive_req(0, 8'h00, 8'h00, 6'h27);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({busy, bus_if.rsp_valid, bus_if.req0_ready} !== 3'b000) begin failures++; $display("FAIL mid_async got=%b exp=000", {busy, bus_if.rsp_valid, bus_if.req0_ready}); end
        checks++; if ({bus_if.alu_op_a_bus, bus_if.alu_op_b_bus, bus_if.alu_op_code_bus} !== 22'h0) begin failures++; $display("FAIL mid_buses got=%h exp=0", {bus_if.alu_op_a_bus, bus_if.alu_op_b_bus, bus_if.alu_op_code_bus}); end
        seen = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
            if (bus_if.rsp_valid === 1'b1) seen = 1'b1;
        end
        reset_n = 1'b1;
        #1;
        if (bus_if.rsp_valid === 1'b1) seen = 1'b1;
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_response got=%b exp=0", seen); end
        checks++; if (bus_if.req0_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after got=%b exp=1", bus_if.req0_ready); end
        @(posedge clock);
        #1;
        bus_if.req0_valid = 1'b0;
        wait_rsp(lat, en);
        checks++; if ({lat[3:0], bus_if.rsp_id, bus_if.rsp_illegal, bus_if.rsp_result} !== {4'd3, 1'b0, 1'b0, 9'h0FF}) begin failures++; $display("FAIL mid_next_txn got=%h exp=%h", {lat[3:0], bus_if.rsp_id, bus_if.rsp_illegal, bus_if.rsp_result}, {4'd3, 1'b0, 1'b0, 9'h0FF}); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_random();
        int lat, en, d;
        logic [1:0]  v;
        logic        g, ill;
        logic [7:0]  a [2];
        logic [7:0]  b [2];
        logic [5:0]  op [2];
        logic [5:0]  legal_ops [8];
        logic [10:0] exp;
        legal_ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
        do_reset();
        m_last = 1'b1;
        bus_if.rsp_ready = 1'b0;
        for (int n = 0; n < 40; n++) begin
            v = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                a[r] = 8'($urandom);
                b[r] = 8'($urandom);
                if ($urandom_range(0, 3) == 0) op[r] = 6'($urandom);
                else op[r] = legal_ops[$urandom_range(0, 7)];
            end
            if (v[0]) drive_req(0, a[0], b[0], op[0]);
            if (v[1]) drive_req(1, a[1], b[1], op[1]);
            #1;
            g = (v == 2'b11) ? ~m_last : v[1];
            checks++; if ({bus_if.req1_ready, bus_if.req0_ready} !== (g ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rand_grant%0d got=%b exp=%b", n, {bus_if.req1_ready, bus_if.req0_ready}, (g ? 2'b10 : 2'b01)); end
            ill = ~op_ok(op[g]);
            exp_q.push_back({g, ill, ill ? 9'h000 : alu_fn(a[g], b[g], op[g])});
            m_last = g;
            @(posedge clock);
            #1;
            bus_if.req0_valid = 1'b0;
            bus_if.req1_valid = 1'b0;
            wait_rsp(lat, en);
            exp = exp_q.pop_front();
            checks++; if (lat != (ill ? 0 : 3) || en != (ill ? 0 : 1)) begin failures++; $display("FAIL rand_timing%0d got=lat%0d/en%0d exp=lat%0d/en%0d", n, lat, en, ill ? 0 : 3, ill ? 0 : 1); end
            checks++; if ({bus_if.rsp_id, bus_if.rsp_illegal, bus_if.rsp_result} !== exp) begin failures++; $display("FAIL rand_rsp%0d got=%h exp=%h", n, {bus_if.rsp_id, bus_if.rsp_illegal, bus_if.rsp_result}, exp); end
            d = $urandom_range(0, 3);
            repeat (d) begin
                @(posedge clock);
                #1;
                checks++; if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_illegal, bus_if.rsp_result} !== {1'b1, exp}) begin failures++; $display("FAIL rand_stable%0d got=%h exp=%h", n, {bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_illegal, bus_if.rsp_result}, {1'b1, exp}); end
            end
            bus_if.rsp_ready = 1'b1;
            @(posedge clock);
            #1;
            bus_if.rsp_ready = 1'b0;
            checks++; if ({busy, bus_if.rsp_valid} !== 2'b00) begin failures++; $display("FAIL rand_idle%0d got=%b exp=00", n, {busy, bus_if.rsp_valid}); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;
        bus_if.req0_a = '0; bus_if.req0_b = '0; bus_if.req0_op = '0;
        bus_if.req1_a = '0; bus_if.req1_b = '0; bus_if.req1_op = '0;
        bus_if.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
